// File: rtl/coeff_dequant_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | coeff_dequant_buffer: zig-zag walk, shift dequantise and NUM_BUF-deep    |
// | block buffer ring. Optional macro DEQ_NZ_COUNT_EN adds rd_nz_count.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module coeff_dequant_buffer #(
  parameter int MAX_N   = 16,
  parameter int COEFF_W = 9,
  parameter int OUT_W   = 16,
  parameter int NUM_BUF = 2
) (
  input  logic                             Clock_50,
  input  logic                             Resetn,
  input  logic                             cfg_mode,
  input  logic                             cfg_q,
  input  logic                             coeff_valid,
  output logic                             coeff_ready,
  input  logic signed [COEFF_W-1:0]        coeff_data,
  input  logic                             coeff_last,
  output logic                             rd_avail,
  input  logic [$clog2(MAX_N*MAX_N/2)-1:0] rd_addr,
  output logic [2*OUT_W-1:0]               rd_data,
  input  logic                             rd_release,
`ifdef DEQ_NZ_COUNT_EN
  output logic [$clog2(MAX_N*MAX_N):0]     rd_nz_count,
`endif
  output logic                             err_overrun
);

  localparam int c_depth = MAX_N * MAX_N / 2;
  localparam int c_aw    = $clog2(c_depth);
  localparam int c_rcw   = $clog2(MAX_N);
  localparam int c_pw    = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
  localparam int c_cw    = $clog2(NUM_BUF + 1);
  localparam int c_ext_w = COEFF_W + 7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_mode, r_q, r_up;
  logic [c_rcw-1:0]   r_row, r_col;
  logic [c_pw-1:0]    r_wr_ptr, r_rd_ptr;
  logic [c_cw-1:0]    r_count;
  logic               r_coeff_ready, r_rd_avail, r_err;
  logic [2*OUT_W-1:0] r_rd_data;
  logic [c_depth-1:0] r_vhi [NUM_BUF];
  logic [c_depth-1:0] r_vlo [NUM_BUF];
  logic [OUT_W-1:0]   r_mem_hi [NUM_BUF][c_depth];
  logic [OUT_W-1:0]   r_mem_lo [NUM_BUF][c_depth];

  logic                      w_hs, w_mode, w_q, w_up, w_at_end, w_done, w_commit, w_rel;
  logic [c_rcw-1:0]          w_nm1, w_row_nx, w_col_nx;
  logic                      w_up_nx;
  logic [5:0]                w_pos;
  logic [2:0]                w_shift;
  logic signed [c_ext_w-1:0] w_ext, w_shl;
  logic [OUT_W-1:0]          w_deq, w_rd_hi, w_rd_lo;
  logic [c_aw-1:0]           w_addr;
  logic [c_cw-1:0]           w_count_nx;
  logic [c_pw-1:0]           w_wr_inc, w_rd_inc;
  state_t                    w_state_nx;

  // In S_IDLE the incoming cfg governs the first coefficient; afterwards the latched copy.
  assign w_hs     = coeff_valid & r_coeff_ready;
  assign w_mode   = (r_state == S_IDLE) ? cfg_mode : r_mode;
  assign w_q      = (r_state == S_IDLE) ? cfg_q    : r_q;
  assign w_up     = (r_state == S_IDLE) ? cfg_mode : r_up;
  assign w_nm1    = w_mode ? c_rcw'(15) : c_rcw'(7);
  assign w_at_end = (r_row == w_nm1) && (r_col == w_nm1);
  assign w_done   = coeff_last | w_at_end;
  assign w_commit = (r_state == S_COMMIT);
  assign w_rel    = rd_release && (r_count != '0);
  assign w_count_nx = r_count + c_cw'(w_commit) - c_cw'(w_rel);
  assign w_wr_inc = (r_wr_ptr == c_pw'(NUM_BUF - 1)) ? '0 : r_wr_ptr + c_pw'(1);
  assign w_rd_inc = (r_rd_ptr == c_pw'(NUM_BUF - 1)) ? '0 : r_rd_ptr + c_pw'(1);
  assign w_pos    = 6'(r_row) + 6'(r_col);
  assign w_addr   = (c_aw'(r_col) << (w_mode ? 3 : 2)) + c_aw'(r_row >> 1);
  assign w_ext    = c_ext_w'(coeff_data);
  assign w_shl    = w_ext <<< w_shift;

  always_comb begin
    w_shift = 3'd5;
    if (!w_q) begin
      if (!w_mode) w_shift = (w_pos <= 6'd6) ? 3'd3 : (w_pos <= 6'd10) ? 3'd4 : 3'd5;
      else         w_shift = (w_pos <= 6'd18) ? 3'd4 : 3'd5;
    end else begin
      if (!w_mode) w_shift = (w_pos <= 6'd3) ? 3'd3 : (w_pos <= 6'd6) ? 3'd4 :
                             (w_pos <= 6'd11) ? 3'd5 : 3'd6;
      else         w_shift = (w_pos <= 6'd5) ? 3'd4 : (w_pos <= 6'd20) ? 3'd5 : 3'd6;
    end
  end

  generate
    if (c_ext_w > OUT_W) begin : g_sat
      logic [c_ext_w-OUT_W:0] w_top;
      assign w_top = w_shl[c_ext_w-1:OUT_W-1];
      always_comb begin
        if ((&w_top) || !(|w_top)) w_deq = w_shl[OUT_W-1:0];
        else if (w_top[c_ext_w-OUT_W]) w_deq = {1'b1, {(OUT_W-1){1'b0}}};
        else w_deq = {1'b0, {(OUT_W-1){1'b1}}};
      end
    end else begin : g_ext
      assign w_deq = OUT_W'(w_shl);
    end
  endgenerate

  // Standard zig-zag step: bounce off the far edge first, then the origin edge.
  always_comb begin
    w_row_nx = r_row;
    w_col_nx = r_col;
    w_up_nx  = w_up;
    if (w_up) begin
      if (r_col == w_nm1) begin w_row_nx = r_row + c_rcw'(1); w_up_nx = 1'b0; end
      else if (r_row == '0) begin w_col_nx = r_col + c_rcw'(1); w_up_nx = 1'b0; end
      else begin w_row_nx = r_row - c_rcw'(1); w_col_nx = r_col + c_rcw'(1); end
    end else begin
      if (r_row == w_nm1) begin w_col_nx = r_col + c_rcw'(1); w_up_nx = 1'b1; end
      else if (r_col == '0) begin w_row_nx = r_row + c_rcw'(1); w_up_nx = 1'b1; end
      else begin w_row_nx = r_row + c_rcw'(1); w_col_nx = r_col - c_rcw'(1); end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE, S_FILL: if (w_hs) w_state_nx = w_done ? S_COMMIT : S_FILL;
      S_COMMIT:       w_state_nx = S_IDLE;
      default:        w_state_nx = S_IDLE;
    endcase
  end

  assign w_rd_hi = r_vhi[r_rd_ptr][rd_addr] ? r_mem_hi[r_rd_ptr][rd_addr] : '0;
  assign w_rd_lo = r_vlo[r_rd_ptr][rd_addr] ? r_mem_lo[r_rd_ptr][rd_addr] : '0;

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_state       <= S_IDLE;
      r_mode        <= 1'b0;
      r_q           <= 1'b0;
      r_up          <= 1'b0;
      r_row         <= '0;
      r_col         <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_coeff_ready <= 1'b0;
      r_rd_avail    <= 1'b0;
      r_err         <= 1'b0;
      r_rd_data     <= '0;
      for (int i = 0; i < NUM_BUF; i++) begin
        r_vhi[i] <= '0;
        r_vlo[i] <= '0;
      end
    end else begin
      r_state       <= w_state_nx;
      r_count       <= w_count_nx;
      r_rd_avail    <= (w_count_nx != '0);
      r_coeff_ready <= (w_state_nx == S_FILL) ||
                       ((w_state_nx == S_IDLE) && (w_count_nx < c_cw'(NUM_BUF)));
      r_rd_data     <= (r_count == '0) ? '0 : {w_rd_hi, w_rd_lo};
      if (w_hs && (r_state == S_IDLE)) begin
        r_mode <= cfg_mode;
        r_q    <= cfg_q;
      end
      if (w_hs) begin
        if (w_done) begin
          r_row <= '0;
          r_col <= '0;
        end else begin
          r_row <= w_row_nx;
          r_col <= w_col_nx;
          r_up  <= w_up_nx;
        end
        if (w_at_end && !coeff_last) r_err <= 1'b1;
      end
      if (rd_release && (r_count == '0)) r_err <= 1'b1;
      if (w_commit) r_wr_ptr <= w_wr_inc;
      if (w_rel) begin
        r_rd_ptr        <= w_rd_inc;
        r_vhi[r_rd_ptr] <= '0;
        r_vlo[r_rd_ptr] <= '0;
      end
      if (w_hs) begin
        if (!r_row[0]) r_vhi[r_wr_ptr][w_addr] <= 1'b1;
        else           r_vlo[r_wr_ptr][w_addr] <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clock_50) begin
    if (w_hs) begin
      if (!r_row[0]) r_mem_hi[r_wr_ptr][w_addr] <= w_deq;
      else           r_mem_lo[r_wr_ptr][w_addr] <= w_deq;
    end
  end

`ifdef DEQ_NZ_COUNT_EN
  logic [$clog2(MAX_N*MAX_N):0] r_nz [NUM_BUF];

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < NUM_BUF; i++) r_nz[i] <= '0;
    end else begin
      if (w_rel) r_nz[r_rd_ptr] <= '0;
      if (w_hs && (coeff_data != '0)) r_nz[r_wr_ptr] <= r_nz[r_wr_ptr] + 1'b1;
    end
  end

  assign rd_nz_count = r_nz[r_rd_ptr];
`endif

  assign coeff_ready = r_coeff_ready;
  assign rd_avail    = r_rd_avail;
  assign rd_data     = r_rd_data;
  assign err_overrun = r_err;

endmodule
`default_nettype wire
